req_grant_responder: RTL and testbench
======================================

# req_grant_responder

Responder end of the request/grant handshake. It samples up to NUM_REQ request lines and picks one winner by round-robin. It returns a registered one-hot grant exactly GRANT_LATENCY clock edges after the winning request was sampled, so the initiator-side property "request |-> ##GRANT_LATENCY grant" holds for every accepted request. It also bounds grant ownership with a hold timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- GRANT_LATENCY, 2, edges from request sample to grant sample (1..15)
- MAX_HOLD, 8, max consecutive cycles one grant may be held (2..255)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- request  in  NUM_REQ  per-requester request level, held high until done
- grant  out  NUM_REQ  registered one-hot (or zero) grant
- grant_id  out  $clog2(NUM_REQ)  index of current/pending winner, valid when busy
- busy  out  1  FSM not in IDLE
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
- abort  out  1  one-cycle pulse when the winner drops request before grant

## Operation
- FSM states: IDLE, WAIT, GRANT, GAP.
- IDLE: at an edge with any request bit high, choose the winner. The winner is the first set bit at or above rr_ptr, wrapping modulo NUM_REQ. Latch it into grant_id.
  - If GRANT_LATENCY=1, go to GRANT and set grant[winner] at this same edge.
  - Otherwise go to WAIT with lat_cnt=1.
- WAIT: at each edge, if request[winner] is low, go to GAP and pulse abort; grant stays 0.
  - Else if lat_cnt == GRANT_LATENCY-1, set grant[winner] and go to GRANT.
  - Else increment lat_cnt.
  - Other requesters are ignored.
- GRANT: hold_cnt counts edges with grant high, starting at 1 on the first such edge.
  - request[winner] low → clear grant and go to GAP.
  - Else hold_cnt == MAX_HOLD → clear grant, pulse timeout, go to GAP.
- GAP: exactly one cycle, grant all zero. Set rr_ptr = (grant_id+1) mod NUM_REQ, then go to IDLE.
  - The ptr advances on normal release, timeout and abort alike.
- A requester whose grant timed out must deassert request for ≥1 cycle. It is only re-eligible after its request has been observed low once.
  - This is tracked by per-requester blocked bits, which clear when that request is seen low.
  - Blocked requests are excluded from arbitration.
- Counters saturate by construction. lat_cnt width is 4 bits and hold_cnt is 8 bits; both reset to 0 on entry to IDLE.

## Timing
- Reset values: grant=0, grant_id=0, busy=0, timeout=0, abort=0, rr_ptr=0, blocked=0, state=IDLE.
- Async reset mid-operation clears grant immediately, without waiting for a clock edge. The first arbitration after reset release considers request at the first rising edge with rst_n high.
- Latency: request sampled high at edge k in IDLE → grant reads 1 in the sampled (preponed) value at edge k+GRANT_LATENCY. The register is updated at edge k+GRANT_LATENCY-1.
- Release: request sampled low at edge m in GRANT → grant reads 0 after edge m and stays 0 for the GAP cycle.
- Minimum spacing between two grants is GRANT_LATENCY+1 edges after the first release.
- If multiple requests rise on the same edge, the tie is broken by rr_ptr order; losers keep waiting with no timeout of their own.
- A request rising during WAIT, GRANT or GAP is not sampled until IDLE.
- If timeout and request drop occur on the same edge, request drop wins and no timeout pulse is generated.
- busy is high from the edge leaving IDLE through the GAP cycle inclusive.
- At most one grant bit is ever high; grant is never high in IDLE, WAIT or GAP.

## Test plan
- Single req, default params: request[0] rises and is sampled at edge 3, held → grant=4'b0001 sampled at edge 5; request drops sampled at edge 7 → grant 0 after edge 7, busy low after edge 8.
- Round robin: request=4'b1111 held constantly → grants in order 0,1,2,3,0. Each grant lasts 8 cycles with a timeout pulse, separated by GAP.
  - A requester must drop its request for one cycle before it is re-granted; the bench toggles requests accordingly.
- Abort: request[2] high at edge 4, low at edge 5 → abort pulse at edge 5, no grant bit ever high, rr_ptr becomes 3.
- Timeout: MAX_HOLD=8, request[1] held 20 cycles → grant high for exactly 8 sampled edges, timeout=1 for one cycle. No re-grant until request[1] goes low then high.
- GRANT_LATENCY=1 and =4 sweeps: property request |-> ##GRANT_LATENCY grant[id] passes on every accepted request across a 500-cycle random request stream.
- Async reset: assert rst_n=0 mid-GRANT between edges → grant=0 immediately, all outputs at reset values. After release, a fresh request is re-arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/req_grant_responder.sv
// rtl/req_grant_responder.sv - round-robin request/grant responder with fixed grant latency
// Four-state FSM (IDLE/WAIT/GRANT/GAP) plus hold timeout and per-requester re-arm blocking.
module req_grant_responder #(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_LATENCY = 2,
  parameter int MAX_HOLD      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         request,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout,
  output logic                       abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
  localparam logic [3:0]         LAT_LAST = 4'(GRANT_LATENCY - 1);
  localparam logic [7:0]         HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] blocked;
  logic [3:0]         lat_cnt;
  logic [7:0]         hold_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IW-1:0]      pick_id;
  logic [IW-1:0]      next_ptr;

  // First eligible requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] idx_w;
    eligible   = request & ~blocked;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    idx_w      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx   = (int'(rr_ptr) + i) % NUM_REQ;
      idx_w = IW'(idx);
      if (!pick_valid && eligible[idx_w]) begin
        pick_valid = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (grant_id != IW'(NUM_REQ - 1)) next_ptr = grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      abort    <= 1'b0;
      rr_ptr   <= '0;
      blocked  <= '0;
      lat_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      abort   <= 1'b0;
      // A blocked requester re-arms once its request is observed low.
      blocked <= blocked & request;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            busy     <= 1'b1;
            if (GRANT_LATENCY == 1) begin
              grant    <= ONE << pick_id;
              hold_cnt <= 8'd1;
              state    <= GRANT;
            end else begin
              lat_cnt <= 4'd1;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!request[grant_id]) begin
            abort <= 1'b1;
            state <= GAP;
          end else if (lat_cnt == LAT_LAST) begin
            grant    <= ONE << grant_id;
            hold_cnt <= 8'd1;
            state    <= GRANT;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        GRANT: begin
          if (!request[grant_id]) begin
            grant <= '0;
            state <= GAP;
          end else if (hold_cnt == HOLD_MAX) begin
            grant             <= '0;
            timeout           <= 1'b1;
            blocked[grant_id] <= 1'b1;
            state             <= GAP;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP: begin
          rr_ptr   <= next_ptr;
          lat_cnt  <= '0;
          hold_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_grant_responder.sv
// tb/tb_req_grant_responder.sv - scoreboard bench for req_grant_responder
// Directed scenarios on the default instance, latency property on GRANT_LATENCY=1 and =4 instances.
module tb_req_grant_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] request, rreq;
  logic [3:0] grant, grant1, grant4;
  logic [1:0] grant_id, gid1, gid4;
  logic       busy, busy1, busy4;
  logic       timeout, to1, to4;
  logic       abort, ab1, ab4;

  req_grant_responder u_dut (
    .clk(clk), .rst_n(rst_n), .request(request), .grant(grant), .grant_id(grant_id),
    .busy(busy), .timeout(timeout), .abort(abort)
  );
  req_grant_responder #(.GRANT_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .request(rreq), .grant(grant1), .grant_id(gid1),
    .busy(busy1), .timeout(to1), .abort(ab1)
  );
  req_grant_responder #(.GRANT_LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .request(rreq), .grant(grant4), .grant_id(gid4),
    .busy(busy4), .timeout(to4), .abort(ab4)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] v);
    enc = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) enc = 2'(i);
  endfunction

  // kind: 0 grant rise, 1 grant release, 2 timeout pulse, 3 abort pulse
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  id;
    logic [31:0] at;
  } ev_t;
  ev_t expq[$];

  task automatic expect_ev(input logic [1:0] k, input int id, input int at);
    expq.push_back({k, 2'(id), 32'(at)});
  endtask

  task automatic observe(input logic [1:0] k, input logic [1:0] id);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected: got kind=%0d id=%0d cyc=%0d want none", k, id, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind !== k || e.id !== id || e.at !== 32'(cyc)) begin
        bad++;
        $display("FAIL sb_event: got kind=%0d id=%0d cyc=%0d want kind=%0d id=%0d cyc=%0d",
                 k, id, cyc, e.kind, e.id, e.at);
      end
    end
  endtask

  logic [3:0] prev_grant;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = 4'd0;
    end else begin
      if (grant != 4'd0 && prev_grant == 4'd0) begin
        observe(2'd0, enc(grant));
        chk("grant_onehot", 32'($onehot(grant)), 32'd1);
      end
      if (grant == 4'd0 && prev_grant != 4'd0) observe(2'd1, enc(prev_grant));
      if (timeout) observe(2'd2, grant_id);
      if (abort)   observe(2'd3, grant_id);
      prev_grant = grant;
    end
  end

  // Latency property on the two swept instances, from a short history of sampled values.
  typedef struct packed {
    logic [3:0] req;
    logic       busy;
    logic [1:0] gid;
    logic [3:0] grant;
  } h_t;
  h_t hh[2][17];
  int arb_cnt[2] = '{0, 0};

  task automatic lat_check(input int n, input int lat);
    logic [1:0] id;
    logic       held;
    if (hh[n][lat-1].busy && !hh[n][lat].busy) begin
      id   = hh[n][lat-1].gid;
      held = 1'b1;
      for (int j = 1; j < lat; j++) if (!hh[n][j].req[id]) held = 1'b0;
      arb_cnt[n]++;
      chk($sformatf("lat%0d_grant", lat), 32'(hh[n][0].grant), held ? 32'(4'b0001 << id) : 32'd0);
    end
    if (hh[n][0].grant != 4'd0 && hh[n][1].grant == 4'd0) begin
      id   = enc(hh[n][0].grant);
      held = 1'b1;
      for (int j = 1; j <= lat; j++) if (!hh[n][j].req[id]) held = 1'b0;
      chk($sformatf("lat%0d_rise", lat),
          32'({held, hh[n][lat-1].busy, hh[n][lat].busy, $onehot(hh[n][0].grant)}), 32'b1101);
    end
  endtask

  always @(negedge clk) begin
    for (int j = 16; j > 0; j--) begin
      hh[0][j] = hh[0][j-1];
      hh[1][j] = hh[1][j-1];
    end
    hh[0][0] = {rreq, busy1, gid1, grant1};
    hh[1][0] = {rreq, busy4, gid4, grant4};
    if (rst_n) begin
      lat_check(0, 1);
      lat_check(1, 4);
      if (to1 | ab1) chk("l1_pulse_excl", 32'(to1 & ab1), 32'd0);
      if (to4 | ab4) chk("l4_pulse_excl", 32'(to4 & ab4), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int e;
  int rr_order[5] = '{2, 3, 0, 1, 2};

  initial begin
    rst_n   = 1'b0;
    request = 4'd0;
    rreq    = 4'd0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request on 0, released after three granted edges
    request = 4'b0001;
    tick(); e = cyc;
    expect_ev(2'd0, 0, e + 1);
    repeat (3) tick();
    expect_ev(2'd1, 0, e + 4);
    request = 4'b0000;
    tick();
    chk("busy_in_gap", 32'(busy), 32'd1);
    tick();
    chk("busy_after_gap", 32'(busy), 32'd0);

    // abort: requester 2 drops before its grant
    request = 4'b0100;
    tick(); e = cyc;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_id", 32'(grant_id), 32'd2);
    expect_ev(2'd3, 2, e + 1);
    request = 4'b0000;
    tick();
    tick();

    // timeout: requester 1 held for 20 edges, then must re-arm
    request = 4'b0010;
    tick(); e = cyc;
    expect_ev(2'd0, 1, e + 1);
    expect_ev(2'd1, 1, e + 9);
    expect_ev(2'd2, 1, e + 9);
    repeat (19) tick();
    chk("blocked_busy", 32'(busy), 32'd0);
    chk("blocked_grant", 32'(grant), 32'd0);
    request = 4'b0000;
    tick();
    request = 4'b0010;
    tick(); e = cyc;
    expect_ev(2'd0, 1, e + 1);
    tick();
    tick();
    expect_ev(2'd1, 1, e + 3);
    request = 4'b0000;
    tick();
    tick();

    // async reset in the middle of a grant to requester 3
    request = 4'b1000;
    tick(); e = cyc;
    expect_ev(2'd0, 3, e + 1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_pulses", 32'({timeout, abort}), 32'd0);
    request = 4'b1010;
    tick();
    #2 rst_n = 1'b1;
    tick(); e = cyc;
    expect_ev(2'd0, 1, e + 1);
    tick();
    tick();
    expect_ev(2'd1, 1, e + 3);
    request = 4'b0000;
    tick();
    tick();

    // round robin with all requesters, each dropping for one cycle after its timeout
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); e = cyc;
      expect_ev(2'd0, rr_order[k], e + 1);
      expect_ev(2'd1, rr_order[k], e + 9);
      expect_ev(2'd2, rr_order[k], e + 9);
      repeat (9) tick();
      request[rr_order[k]] = 1'b0;
      tick();
      request[rr_order[k]] = 1'b1;
    end
    request = 4'b0000;
    tick();
    tick();
    chk("sb_drain", 32'(expq.size()), 32'd0);

    // random request stream for the latency-swept instances
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) rreq[b] = ~rreq[b];
      tick();
    end
    rreq = 4'd0;
    repeat (12) tick();
    chk("l1_activity", 32'(arb_cnt[0] > 10), 32'd1);
    chk("l4_activity", 32'(arb_cnt[1] > 10), 32'd1);
    chk("sb_drain_end", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
